// File: rtl/odd_even_issue_ctrl.sv
// Dual-issue scheduler between decode and the even/odd execution pipes.
// Holds one decoded pair and issues it in order once RAW, WAW and pipe
// hazards clear. A per-register countdown scoreboard tracks in-flight results.
module odd_even_issue_ctrl #(
   parameter int NREG = 128,
   parameter int LATW = 3,
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 a_valid,
   input  logic                 b_valid,
   input  logic                 a_pipe,
   input  logic                 b_pipe,
   input  logic [LATW-1:0]      a_lat,
   input  logic [LATW-1:0]      b_lat,
   input  logic                 a_wr,
   input  logic                 b_wr,
   input  logic [6:0]           a_rt,
   input  logic [6:0]           b_rt,
   input  logic [2:0][6:0]      a_src,
   input  logic [2:0][6:0]      b_src,
   input  logic [2:0]           a_use,
   input  logic [2:0]           b_use,
   input  logic                 flush,
   output logic                 issue_even,
   output logic                 issue_odd,
   output logic                 even_slot,
   output logic                 odd_slot,
   output logic                 stall,
   output logic [NREG-1:0]      sb_busy,
   output logic [CNTW-1:0]      stall_cycles
);

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_PAIR   = 2'd1,
      ST_SINGLE = 2'd2
   } state_t;

   typedef struct packed {
      logic            valid;
      logic            pipe;
      logic [LATW-1:0] lat;
      logic            wr;
      logic [6:0]      rt;
      logic [2:0][6:0] src;
      logic [2:0]      srcv;
   } slot_t;

   state_t          state_reg, state_next;
   slot_t           a_reg, b_reg;
   logic [CNTW-1:0] stall_cycles_reg;
   logic [LATW-1:0] cnt_reg [NREG];

   logic a_hazard, b_hazard, pair_conflict;
   logic a_issue, b_issue, a_done, b_done;
   logic held, all_issue, accept;
   logic a_load, b_load;

   // A source or destination that is still counting down blocks the instruction.
   function automatic logic hazard(input slot_t s, input logic [NREG-1:0] busy);
      logic h;
      h = s.wr & busy[s.rt];
      for (int k = 0; k < 3; k++) begin
         h = h | (s.srcv[k] & busy[s.src[k]]);
      end
      return h;
   endfunction

   // B cannot share the issue cycle if it reads or rewrites A's destination.
   function automatic logic conflict(input slot_t a, input slot_t b);
      logic c;
      c = (a.rt == b.rt);
      for (int k = 0; k < 3; k++) begin
         c = c | (b.srcv[k] & (b.src[k] == a.rt));
      end
      return a.wr & c;
   endfunction

   assign a_hazard      = hazard(a_reg, sb_busy);
   assign b_hazard      = hazard(b_reg, sb_busy);
   assign pair_conflict = conflict(a_reg, b_reg);

   // Issue decision for the held instructions; an empty slot counts as done.
   always_comb begin
      a_issue = 1'b0;
      b_issue = 1'b0;
      a_done  = 1'b1;
      b_done  = 1'b1;
      case (state_reg)
         ST_PAIR: begin
            a_issue = a_reg.valid & ~a_hazard;
            a_done  = ~a_reg.valid | ~a_hazard;
            b_issue = b_reg.valid & a_done & ~b_hazard &
                      (~a_reg.valid | ((b_reg.pipe != a_reg.pipe) & ~pair_conflict));
            b_done  = ~b_reg.valid | b_issue;
         end
         ST_SINGLE: begin
            b_issue = ~b_hazard;
            b_done  = ~b_hazard;
         end
         default: begin
            a_issue = 1'b0;
            b_issue = 1'b0;
         end
      endcase
   end

   assign held      = (state_reg != ST_EMPTY);
   assign all_issue = a_done & b_done;
   assign in_ready  = ~flush & (~held | all_issue);
   assign accept    = in_valid & in_ready;
   assign stall     = held & ~all_issue & ~flush;

   assign issue_even = (a_issue & ~a_reg.pipe) | (b_issue & ~b_reg.pipe);
   assign issue_odd  = (a_issue &  a_reg.pipe) | (b_issue &  b_reg.pipe);
   assign even_slot  = b_issue & ~b_reg.pipe;
   assign odd_slot   = b_issue &  b_reg.pipe;

   assign a_load = a_issue & a_reg.wr & (a_reg.lat != '0);
   assign b_load = b_issue & b_reg.wr & (b_reg.lat != '0);

   // Next-state selection: flush wins, then a new pair, then issue progress.
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = ST_EMPTY;
      end else if (accept) begin
         state_next = (a_valid | b_valid) ? ST_PAIR : ST_EMPTY;
      end else begin
         case (state_reg)
            ST_PAIR:   state_next = all_issue ? ST_EMPTY : (a_done ? ST_SINGLE : ST_PAIR);
            ST_SINGLE: state_next = b_done ? ST_EMPTY : ST_SINGLE;
            default:   state_next = ST_EMPTY;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // Capture the offered pair when it is accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg <= '0;
         b_reg <= '0;
      end else if (accept) begin
         a_reg.valid <= a_valid;
         a_reg.pipe  <= a_pipe;
         a_reg.lat   <= a_lat;
         a_reg.wr    <= a_wr;
         a_reg.rt    <= a_rt;
         a_reg.src   <= a_src;
         a_reg.srcv  <= a_use;
         b_reg.valid <= b_valid;
         b_reg.pipe  <= b_pipe;
         b_reg.lat   <= b_lat;
         b_reg.wr    <= b_wr;
         b_reg.rt    <= b_rt;
         b_reg.src   <= b_src;
         b_reg.srcv  <= b_use;
      end
   end

   // Saturating count of cycles in which a held instruction was blocked.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_reg <= '0;
      end else if (stall && (stall_cycles_reg != {CNTW{1'b1}})) begin
         stall_cycles_reg <= stall_cycles_reg + 1'b1;
      end
   end

   assign stall_cycles = stall_cycles_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_sb
         // Per-register countdown; a new issue load overrides the decrement.
         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_reg[gi] <= '0;
            end else if (b_load && (b_reg.rt == 7'(gi))) begin
               cnt_reg[gi] <= b_reg.lat;
            end else if (a_load && (a_reg.rt == 7'(gi))) begin
               cnt_reg[gi] <= a_reg.lat;
            end else if (cnt_reg[gi] != '0) begin
               cnt_reg[gi] <= cnt_reg[gi] - 1'b1;
            end
         end

         assign sb_busy[gi] = (cnt_reg[gi] != '0);
      end
   endgenerate

endmodule

// File: tb/tb_odd_even_issue_ctrl.sv
// Bench for odd_even_issue_ctrl: directed scenarios plus random pairs,
// compared each cycle against a queue-based model of in-order dual issue.
module tb_odd_even_issue_ctrl;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic             a_valid, b_valid;
   logic             a_pipe, b_pipe;
   logic [2:0]       a_lat, b_lat;
   logic             a_wr, b_wr;
   logic [6:0]       a_rt, b_rt;
   logic [2:0][6:0]  a_src, b_src;
   logic [2:0]       a_use, b_use;
   logic             flush;
   logic             issue_even, issue_odd, even_slot, odd_slot, stall;
   logic [127:0]     sb_busy;
   logic [15:0]      stall_cycles;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct packed {
      bit            slot;
      bit            pipe;
      bit [2:0]      lat;
      bit            wr;
      bit [6:0]      rt;
      bit [2:0][6:0] src;
      bit [2:0]      sv;
   } ins_t;

   ins_t q[$];
   int   cnt_m [128];
   int   sc_m;

   odd_even_issue_ctrl #(.NREG(128), .LATW(3), .CNTW(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a_valid(a_valid), .b_valid(b_valid), .a_pipe(a_pipe), .b_pipe(b_pipe),
      .a_lat(a_lat), .b_lat(b_lat), .a_wr(a_wr), .b_wr(b_wr),
      .a_rt(a_rt), .b_rt(b_rt), .a_src(a_src), .b_src(b_src),
      .a_use(a_use), .b_use(b_use), .flush(flush),
      .issue_even(issue_even), .issue_odd(issue_odd),
      .even_slot(even_slot), .odd_slot(odd_slot), .stall(stall),
      .sb_busy(sb_busy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic bit ins_ok(ins_t x);
      if (x.wr && cnt_m[x.rt] > 0) return 1'b0;
      for (int k = 0; k < 3; k++)
         if (x.sv[k] && cnt_m[x.src[k]] > 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit intra(ins_t a, ins_t b);
      if (!a.wr) return 1'b0;
      if (a.rt == b.rt) return 1'b1;
      for (int k = 0; k < 3; k++)
         if (b.sv[k] && b.src[k] == a.rt) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: compare at the falling edge, advance the model after the rising edge.
   task automatic step();
      bit i0, i1, all, e_ready, e_stall, acc;
      bit e_ev, e_od, e_evs, e_ods;
      logic [127:0] e_busy;
      ins_t x;
      @(negedge clk);
      i0 = (q.size() >= 1) && ins_ok(q[0]);
      i1 = (q.size() == 2) && i0 && (q[1].pipe != q[0].pipe) && ins_ok(q[1]) && !intra(q[0], q[1]);
      all = (q.size() == 0) || (i0 && (q.size() == 1 || i1));
      e_ready = !flush && all;
      e_stall = (q.size() > 0) && !all && !flush;
      e_ev = 0; e_od = 0; e_evs = 0; e_ods = 0;
      if (i0) begin
         if (q[0].pipe) begin e_od = 1; e_ods = q[0].slot; end
         else           begin e_ev = 1; e_evs = q[0].slot; end
      end
      if (i1) begin
         if (q[1].pipe) begin e_od = 1; e_ods = q[1].slot; end
         else           begin e_ev = 1; e_evs = q[1].slot; end
      end
      for (int r = 0; r < 128; r++) e_busy[r] = (cnt_m[r] > 0);
      check("in_ready", 128'(in_ready), 128'(e_ready));
      check("issue_even", 128'(issue_even), 128'(e_ev));
      check("issue_odd", 128'(issue_odd), 128'(e_od));
      check("even_slot", 128'(even_slot), 128'(e_evs));
      check("odd_slot", 128'(odd_slot), 128'(e_ods));
      check("stall", 128'(stall), 128'(e_stall));
      check("sb_busy", sb_busy, e_busy);
      check("stall_cycles", 128'(stall_cycles), 128'(sc_m));
      acc = in_valid && e_ready;
      $display("cyc=%0d rst=%0b acc=%0b flush=%0b ev=%0b/%0b od=%0b/%0b stall=%0b held=%0d",
               cyc, reset, acc && !reset, flush, e_ev, e_evs, e_od, e_ods, e_stall, q.size());
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         q.delete();
         for (int r = 0; r < 128; r++) cnt_m[r] = 0;
         sc_m = 0;
      end else begin
         if (e_stall && sc_m < 65535) sc_m++;
         for (int r = 0; r < 128; r++) if (cnt_m[r] > 0) cnt_m[r]--;
         if (i0 && q[0].wr && q[0].lat != 0) cnt_m[q[0].rt] = int'(q[0].lat);
         if (i1 && q[1].wr && q[1].lat != 0) cnt_m[q[1].rt] = int'(q[1].lat);
         if (i1) void'(q.pop_front());
         if (i0) void'(q.pop_front());
         if (flush) q.delete();
         if (acc) begin
            if (a_valid) begin
               x = '{slot: 1'b0, pipe: a_pipe, lat: a_lat, wr: a_wr, rt: a_rt, src: a_src, sv: a_use};
               q.push_back(x);
            end
            if (b_valid) begin
               x = '{slot: 1'b1, pipe: b_pipe, lat: b_lat, wr: b_wr, rt: b_rt, src: b_src, sv: b_use};
               q.push_back(x);
            end
         end
      end
   endtask

   task automatic idle_inputs();
      in_valid = 0; flush = 0;
      a_valid = 0; a_pipe = 0; a_lat = 0; a_wr = 0; a_rt = 0; a_src = '0; a_use = 0;
      b_valid = 0; b_pipe = 0; b_lat = 0; b_wr = 0; b_rt = 0; b_src = '0; b_use = 0;
   endtask

   task automatic rand_inputs();
      in_valid = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      a_valid  = ($urandom_range(0, 7) != 0);
      b_valid  = ($urandom_range(0, 7) != 0);
      a_pipe   = 1'($urandom_range(0, 1));
      b_pipe   = 1'($urandom_range(0, 1));
      a_lat    = 3'($urandom_range(0, 7));
      b_lat    = 3'($urandom_range(0, 7));
      a_wr     = ($urandom_range(0, 3) != 0);
      b_wr     = ($urandom_range(0, 3) != 0);
      a_rt     = 7'($urandom_range(0, 7));
      b_rt     = 7'($urandom_range(0, 7));
      a_use    = 3'($urandom_range(0, 7));
      b_use    = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
         a_src[k] = 7'($urandom_range(0, 7));
         b_src[k] = 7'($urandom_range(0, 7));
      end
   endtask

   initial begin
      for (int r = 0; r < 128; r++) cnt_m[r] = 0;
      sc_m = 0;
      idle_inputs();
      reset = 1;
      // Power-up reset; outputs of the held-idle state checked afterwards.
      @(posedge clk); #1;
      step();
      reset = 0;
      step();
      step();

      // Independent pair: A even r5 lat 6, B odd r9 lat 4.
      in_valid = 1;
      a_valid = 1; a_pipe = 0; a_wr = 1; a_rt = 7'd5; a_lat = 3'd6;
      b_valid = 1; b_pipe = 1; b_wr = 1; b_rt = 7'd9; b_lat = 3'd4;
      step();
      idle_inputs();
      for (int i = 0; i < 9; i++) step();

      // A even writes r10, B odd reads r10; flush while B waits in SINGLE.
      in_valid = 1;
      a_valid = 1; a_pipe = 0; a_wr = 1; a_rt = 7'd10; a_lat = 3'd5;
      b_valid = 1; b_pipe = 1; b_wr = 0; b_src[0] = 7'd10; b_use = 3'b001;
      step();
      idle_inputs();
      step();
      step();
      flush = 1;
      step();
      flush = 0;
      for (int i = 0; i < 6; i++) step();

      // Same-pipe pair: B follows A one cycle later.
      in_valid = 1;
      a_valid = 1; a_pipe = 1; a_wr = 1; a_rt = 7'd7; a_lat = 3'd1;
      b_valid = 1; b_pipe = 1; b_wr = 0; b_src[0] = 7'd1; b_use = 3'b001;
      step();
      idle_inputs();
      for (int i = 0; i < 3; i++) step();

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         rand_inputs();
         step();
      end
      idle_inputs();
      for (int i = 0; i < 10; i++) step();

      // Reset while r20 counts down and a dependent B is held.
      in_valid = 1;
      a_valid = 1; a_pipe = 0; a_wr = 1; a_rt = 7'd20; a_lat = 3'd5;
      b_valid = 1; b_pipe = 0; b_wr = 0; b_src[1] = 7'd20; b_use = 3'b010;
      step();
      idle_inputs();
      step();
      step();
      reset = 1;
      step();
      reset = 0;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
